// File: rtl/comparador_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
package comparador_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Result flags packed as {gt, lt, eq}; RES_NONE means the compare is not yet decided.
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  // Offset-binary view of a sign bit: inverting it makes a two's-complement
  // order match the unsigned order.
  function automatic logic sign_flip(input logic msb, input logic flip);
    return msb ^ flip;
  endfunction

endpackage

// File: rtl/comparador_digito.sv
// Combinational compare of one DIGIT-bit digit; flip_i selects the offset-binary
// view of the digit's top bit (used only for the operand's most significant digit).
module comparador_digito
  import comparador_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             flip_i,
  output logic             gt_o,
  output logic             lt_o
);

  logic [DIGIT-1:0] a_x;
  logic [DIGIT-1:0] b_x;

  always_comb begin
    a_x            = a_i;
    b_x            = b_i;
    a_x[DIGIT-1]   = sign_flip(a_i[DIGIT-1], flip_i);
    b_x[DIGIT-1]   = sign_flip(b_i[DIGIT-1], flip_i);
  end

  assign gt_o = (a_x > b_x);
  assign lt_o = (a_x < b_x);

endmodule

// File: rtl/comparador_secuencial_param.sv
// Digit-serial magnitude comparator: MSB digit first, early exit on the first
// differing digit, registered flags with a start/busy/done handshake.
module comparador_secuencial_param
  import comparador_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             q,
  output logic             q_lt,
  output logic             q_eq
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              signed_q;
  logic [IDXW-1:0]   idx_q;
  logic              busy_q;
  logic              done_q;
  logic [2:0]        flags_q;

  logic              dig_gt;
  logic              dig_lt;
  logic              flip;
  logic              last_dig;
  logic [2:0]        res_d;

  // Operands shift left as digits are consumed, so the digit under test is always the top one.
  assign flip     = signed_q & (idx_q == '0);
  assign last_dig = (idx_q == IDXW'(NDIG - 1));

  comparador_digito #(
    .DIGIT (DIGIT)
  ) u_digito (
    .a_i    (a_q[WIDTH-1 -: DIGIT]),
    .b_i    (b_q[WIDTH-1 -: DIGIT]),
    .flip_i (flip),
    .gt_o   (dig_gt),
    .lt_o   (dig_lt)
  );

  always_comb begin
    res_d = RES_NONE;
    if (dig_gt) begin
      res_d = RES_GT;
    end else if (dig_lt) begin
      res_d = RES_LT;
    end else if (last_dig) begin
      res_d = RES_EQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= RES_NONE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            signed_q <= signed_mode;
            idx_q    <= '0;
            flags_q  <= RES_NONE;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (res_d != RES_NONE) begin
            flags_q <= res_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
            a_q   <= a_q << DIGIT;
            b_q   <= b_q << DIGIT;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = flags_q[2];
  assign q_lt = flags_q[1];
  assign q_eq = flags_q[0];

endmodule

// File: tb/tb_comparador_secuencial_param.sv
// Bench for the digit-serial comparator: table vectors, hand-written corner
// sequences and random operands against an arithmetic reference model.
module tb_comparador_secuencial_param;

  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_LT = 3'b010;
  localparam logic [2:0] F_EQ = 3'b001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sm  = 1'b0;
  logic [31:0] A   = '0;
  logic [31:0] B   = '0;
  logic [2:0]  start_v = '0;
  logic [2:0]  busy_v, done_v, q_v, lt_v, eq_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // DUT 0: DIGIT=8, DUT 1: DIGIT=32 (NDIG=1), DUT 2: DIGIT=1 (NDIG=32)
  comparador_secuencial_param #(.WIDTH(32), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm), .A(A), .B(B),
    .busy(busy_v[0]), .done(done_v[0]), .q(q_v[0]), .q_lt(lt_v[0]), .q_eq(eq_v[0]));
  comparador_secuencial_param #(.WIDTH(32), .DIGIT(32)) u_d32 (
    .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm), .A(A), .B(B),
    .busy(busy_v[1]), .done(done_v[1]), .q(q_v[1]), .q_lt(lt_v[1]), .q_eq(eq_v[1]));
  comparador_secuencial_param #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm), .A(A), .B(B),
    .busy(busy_v[2]), .done(done_v[2]), .q(q_v[2]), .q_lt(lt_v[2]), .q_eq(eq_v[2]));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [2:0]  res;
    int          cyc;
  } vec_t;

  function automatic logic [2:0] flags(input int d);
    return {q_v[d], lt_v[d], eq_v[d]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: ordering from plain integer arithmetic; cycles from the position
  // of the highest differing bit (its digit is the first one that can differ).
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int digit, output logic [2:0] res, output int cyc);
    logic [31:0] x;
    int p;
    x = a ^ b;
    if (a == b) res = F_EQ;
    else if (s ? ($signed(a) > $signed(b)) : (a > b)) res = F_GT;
    else res = F_LT;
    if (a == b) begin
      cyc = 32 / digit;
    end else begin
      p = 0;
      for (int i = 31; i >= 0; i--) begin
        if (x[i]) begin p = i; break; end
      end
      cyc = (31 - p) / digit + 1;
    end
  endtask

  // Drives start for one edge; returns just after the accepting edge.
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    A = a; B = b; sm = s;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
  endtask

  // Counts edges until done; busy_ok tracks busy=1/flags=0 while running and busy=0 at done.
  task automatic wait_done(input int d, output logic [2:0] flg, output int cyc, output bit busy_ok);
    busy_ok = (busy_v[d] === 1'b1) && (flags(d) === 3'b000) && (done_v[d] === 1'b0);
    cyc = 0;
    while (cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (done_v[d] === 1'b1) break;
      if (busy_v[d] !== 1'b1 || flags(d) !== 3'b000) busy_ok = 1'b0;
    end
    if (busy_v[d] !== 1'b0) busy_ok = 1'b0;
    flg = flags(d);
  endtask

  task automatic run_check(input string name, input int d, input int digit,
                           input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [2:0] flg, eres;
    int cyc, ecyc;
    bit bok;
    model(a, b, s, digit, eres, ecyc);
    issue(d, a, b, s);
    wait_done(d, flg, cyc, bok);
    chk({name, "_flags"}, 64'(flg), 64'(eres));
    chk({name, "_cycles"}, 64'(cyc), 64'(ecyc));
    chk({name, "_busy"}, 64'(bok), 64'd1);
  endtask

  vec_t tbl[8];
  logic [2:0] flg;
  int cyc, ndone, dedge;
  bit bok;
  logic [31:0] ra, rb;

  initial begin
    tbl[0] = '{32'h12345678, 32'h12345677, 1'b0, F_GT, 4};
    tbl[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, F_GT, 1};
    tbl[2] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, F_LT, 1};
    tbl[3] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, F_EQ, 4};
    tbl[4] = '{32'h00000001, 32'h00000002, 1'b0, F_LT, 4};
    tbl[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, F_LT, 1};
    tbl[6] = '{32'h00010000, 32'h0000FFFF, 1'b0, F_GT, 2};
    tbl[7] = '{32'hFFFFFF80, 32'hFFFFFF7F, 1'b1, F_GT, 4};

    #12;
    chk("reset_outputs", 64'({busy_v, done_v, q_v, lt_v, eq_v}), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Table vectors on the DIGIT=8 instance, plus the one-cycle done pulse.
    for (int i = 0; i < 8; i++) begin
      issue(0, tbl[i].a, tbl[i].b, tbl[i].s);
      wait_done(0, flg, cyc, bok);
      chk($sformatf("tbl%0d_flags", i), 64'(flg), 64'(tbl[i].res));
      chk($sformatf("tbl%0d_cycles", i), 64'(cyc), 64'(tbl[i].cyc));
      chk($sformatf("tbl%0d_busy", i), 64'(bok), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_hold", i), 64'({done_v[0], busy_v[0], flags(0)}), 64'({2'b00, tbl[i].res}));
    end

    // Back-to-back: start asserted in the done cycle is accepted.
    issue(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    wait_done(0, flg, cyc, bok);
    chk("b2b_first", 64'({flg, 8'(cyc)}), 64'({F_EQ, 8'd4}));
    A = 32'h00000001; B = 32'h00000002; sm = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, flg, cyc, bok);
    chk("b2b_second", 64'({flg, 8'(cyc), 7'd0, bok}), 64'({F_LT, 8'd4, 8'd1}));

    // Start while busy is ignored.
    issue(0, 32'h000000FF, 32'h000000FE, 1'b0);
    ndone = 0; dedge = 0; flg = '0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin A = 32'h0; B = 32'hFFFFFFFF; start_v[0] = 1'b1; end
      if (e == 2) start_v[0] = 1'b0;
      if (done_v[0] === 1'b1) begin ndone++; dedge = e; flg = flags(0); end
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);
    chk("busy_start_edge", 64'(dedge), 64'd4);
    chk("busy_start_flags", 64'(flg), 64'(F_GT));

    // Asynchronous reset in the middle of an equal-operand compare.
    issue(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1 chk("midrst_outputs", 64'({busy_v[0], done_v[0], flags(0)}), 64'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_v[0] === 1'b1) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    run_check("after_rst", 0, 8, 32'h12345678, 32'h12345677, 1'b0);

    // Degenerate digit sizes.
    run_check("ndig1_eq", 1, 32, 32'd5, 32'd5, 1'b0);
    run_check("digit1_gt", 2, 1, 32'h00000001, 32'h00000000, 1'b0);

    // Random operands; biased so late and equal digits are common.
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 2))
        0:       rb = $urandom;
        1:       rb = ra;
        default: rb = ra ^ (32'h1 << $urandom_range(0, 31));
      endcase
      run_check($sformatf("rnd8_%0d", i), 0, 8, ra, rb, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? (ra ^ (32'h1 << $urandom_range(0, 31))) : $urandom;
      run_check($sformatf("rnd1_%0d", i), 2, 1, ra, rb, 1'($urandom_range(0, 1)));
      run_check($sformatf("rnd32_%0d", i), 1, 32, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
